reservoir_fill_controller: RTL and testbench

- Supply-side counterpart of the sprinkler logic: keeps the irrigation reservoir filled through an inlet valve.
- Debounces the three raw float-switch level sensors and runs a fill FSM with hysteresis, a timeout and a sensor-consistency check.
- Exports the debounced mid-level flag that the sprinkler path uses as its water-level input.

---
 rtl/reservoir_fill_controller.sv | 157 +++++++++++++++
 tb/tb_reservoir_fill_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/reservoir_fill_controller.sv
// Reservoir fill controller: debounces three float switches and drives the
// inlet valve through a fill FSM with hysteresis, a fill timeout and a
// sensor-consistency check. The debounced mid level is exported as
// water_available for the sprinkler path.
module reservoir_fill_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FILL_TIMEOUT    = 1024,
  parameter int unsigned TIMER_W         = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       fault_clear,
  output logic       inlet_valve,
  output logic       water_available,
  output logic [2:0] level_stable,
  output logic       fault,
  output logic [1:0] fault_code
);

  // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1; the flip happens on
  // the edge where it would reach DEBOUNCE_CYCLES.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(FILL_TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_INCONS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         fault_code_q, fault_code_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         stable_q, stable_d;
  logic [CNT_W-1:0]   db_cnt_q [3];
  logic [CNT_W-1:0]   db_cnt_d [3];
  logic [2:0]         raw_s;
  logic               inconsistent_s;

  // Bit order {high, mid, low} matches level_stable.
  assign raw_s = {high_water_level, mid_water_level, low_water_level};

  // Per-sensor debounce: count disagreements, flip stable after a full run,
  // any agreement (bounce) restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (raw_s[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == CNT_LAST) begin
        stable_d[i] = raw_s[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // A higher float switch wet while a lower one is dry is physically impossible.
  assign inconsistent_s = (stable_q[2] & ~stable_q[1]) | (stable_q[1] & ~stable_q[0]);

  // Fill FSM next state, fault cause and fill timer.
  // Priority: inconsistency, then high reached, then timeout.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    timer_d      = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (inconsistent_s) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_INCONS;
        end else if (!stable_q[1]) begin
          state_d = ST_FILLING;
          timer_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILLING: begin
        // Saturating timer: never wraps back to a small value.
        if (timer_q != {TIMER_W{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = timer_q;
        end
        if (inconsistent_s) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_INCONS;
        end else if (stable_q[2]) begin
          state_d = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_TIMEOUT;
        end else begin
          state_d = ST_FILLING;
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          if (inconsistent_s) begin
            state_d      = ST_FAULT;
            fault_code_d = CODE_INCONS;
          end else begin
            state_d      = ST_IDLE;
            fault_code_d = CODE_NONE;
          end
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        fault_code_d = CODE_NONE;
        timer_d      = '0;
      end
    endcase
  end

  // State, timer, fault cause and debounce registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fault_code_q <= CODE_NONE;
      timer_q      <= '0;
      stable_q     <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      timer_q      <= timer_d;
      stable_q     <= stable_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Moore outputs decoded from registered state; reset closes the valve at once.
  assign inlet_valve     = (state_q == ST_FILLING);
  assign fault           = (state_q == ST_FAULT);
  assign fault_code      = fault_code_q;
  assign level_stable    = stable_q;
  assign water_available = stable_q[1];

endmodule

// File: tb/tb_reservoir_fill_controller.sv
// Directed self-checking bench for reservoir_fill_controller
// (FILL_TIMEOUT = 16, DEBOUNCE_CYCLES = 4).
module tb_reservoir_fill_controller;

  logic       clk;
  logic       reset;
  logic       low_w, mid_w, high_w;
  logic       fault_clear;
  logic       inlet_valve;
  logic       water_available;
  logic [2:0] level_stable;
  logic       fault;
  logic [1:0] fault_code;

  int checks;
  int failures;

  reservoir_fill_controller #(
    .DEBOUNCE_CYCLES(4),
    .FILL_TIMEOUT   (16),
    .TIMER_W        (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .low_water_level (low_w),
    .mid_water_level (mid_w),
    .high_water_level(high_w),
    .fault_clear     (fault_clear),
    .inlet_valve     (inlet_valve),
    .water_available (water_available),
    .level_stable    (level_stable),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report any mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] v);
    {high_w, mid_w, low_w} = v;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    fault_clear = 1'b0;
    set_raw(3'b000);
    tick(2);

    // Reset state
    chk("rst_valve", inlet_valve, 0);
    chk("rst_water", water_available, 0);
    chk("rst_level", level_stable, 3'b000);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 2'b00);

    // 1: fill up with hysteresis
    reset = 1'b0;
    tick(1);
    chk("t1_fill_start", inlet_valve, 1);
    set_raw(3'b001);
    tick(3);
    chk("t1_low_early", level_stable, 3'b000);
    tick(1);
    chk("t1_low_stable", level_stable, 3'b001);
    tick(1);
    set_raw(3'b011);
    tick(3);
    chk("t1_mid_early", level_stable, 3'b001);
    tick(1);
    chk("t1_mid_stable", level_stable, 3'b011);
    chk("t1_water_on", water_available, 1);
    chk("t1_valve_mid", inlet_valve, 1);
    tick(1);
    set_raw(3'b111);
    tick(4);
    chk("t1_high_stable", level_stable, 3'b111);
    chk("t1_valve_still", inlet_valve, 1);
    tick(1);
    chk("t1_valve_off", inlet_valve, 0);
    set_raw(3'b001);
    tick(4);
    chk("t1_drop_level", level_stable, 3'b001);
    chk("t1_drop_water", water_available, 0);
    chk("t1_drop_valve", inlet_valve, 0);
    tick(1);
    chk("t1_reopen", inlet_valve, 1);

    // 3: fill timeout after 16 FILLING cycles
    tick(15);
    chk("t3_pre_fault", fault, 0);
    chk("t3_pre_valve", inlet_valve, 1);
    tick(1);
    chk("t3_fault", fault, 1);
    chk("t3_code", fault_code, 2'b01);
    chk("t3_valve", inlet_valve, 0);

    // 2: bouncing mid sensor never debounces
    for (int k = 0; k < 10; k++) begin
      set_raw(3'b011);
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk("t2_water", water_available, 0);
      end
      set_raw(3'b001);
      tick(1);
      chk("t2_level_mid", level_stable[1], 0);
    end

    // 3 (cont): clear timeout fault, refill resumes
    pulse_clear();
    chk("t3_clr_fault", fault, 0);
    chk("t3_clr_code", fault_code, 2'b00);
    chk("t3_clr_valve", inlet_valve, 0);
    tick(1);
    chk("t3_refill", inlet_valve, 1);

    // 4: sensor inconsistency
    set_raw(3'b101);
    tick(4);
    chk("t4_level", level_stable, 3'b101);
    chk("t4_no_fault_yet", fault, 0);
    tick(1);
    chk("t4_fault", fault, 1);
    chk("t4_code", fault_code, 2'b10);
    chk("t4_valve", inlet_valve, 0);
    pulse_clear();
    chk("t4_clr_ignored", fault, 1);
    chk("t4_clr_code", fault_code, 2'b10);
    set_raw(3'b111);
    tick(4);
    chk("t4_level_fixed", level_stable, 3'b111);
    pulse_clear();
    chk("t4_cleared", fault, 0);
    chk("t4_code_none", fault_code, 2'b00);
    tick(1);
    chk("t4_idle_full", inlet_valve, 0);

    // 5: asynchronous reset mid-fill
    set_raw(3'b001);
    tick(4);
    chk("t5_level", level_stable, 3'b001);
    tick(1);
    chk("t5_filling", inlet_valve, 1);
    tick(2);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_async_valve", inlet_valve, 0);
    chk("t5_async_level", level_stable, 3'b000);
    chk("t5_async_water", water_available, 0);
    chk("t5_async_fault", fault, 0);
    chk("t5_async_code", fault_code, 2'b00);
    set_raw(3'b111);
    #2;
    reset = 1'b0;
    tick(1);
    chk("t5_refill", inlet_valve, 1);
    chk("t5_level0", level_stable, 3'b000);
    tick(3);
    chk("t5_level_full", level_stable, 3'b111);
    chk("t5_valve_full", inlet_valve, 1);
    tick(1);
    chk("t5_idle", inlet_valve, 0);

    // 6: high reached on the timeout edge wins; fault_clear outside FAULT ignored
    set_raw(3'b001);
    tick(4);
    tick(1);
    chk("t6_filling", inlet_valve, 1);
    tick(3);
    pulse_clear();
    chk("t6_clr_noeffect_valve", inlet_valve, 1);
    chk("t6_clr_noeffect_fault", fault, 0);
    tick(7);
    set_raw(3'b111);
    tick(3);
    chk("t6_level_early", level_stable, 3'b001);
    tick(1);
    chk("t6_level_full", level_stable, 3'b111);
    chk("t6_valve_on", inlet_valve, 1);
    chk("t6_fault_pre", fault, 0);
    tick(1);
    chk("t6_valve_off", inlet_valve, 0);
    chk("t6_no_fault", fault, 0);
    chk("t6_code", fault_code, 2'b00);
    tick(1);
    chk("t6_stay_idle", inlet_valve, 0);
    chk("t6_stay_nofault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
